// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver + {HEADER, CMD, CHK} frame decoder feeding a valid/ready command holding register.
// Latency: command visible one clock after the checksum byte's stop-bit sample; FRAME_TIMEOUT_EN adds an inter-byte timeout.
// Backpressure: one-entry holding register; a good frame arriving while it is full and not being taken is dropped with an overrun pulse.
module uart_cmd_rx #(
    parameter int          CLK_FREQ     = 50_000_000,
    parameter int          BAUD         = 115_200,
    parameter logic [7:0]  HEADER       = 8'hA5,
    parameter int          TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_in,
    output logic [3:0] move_cmd,
    output logic [3:0] speed_level,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);

    if (CLKS_PER_BIT < 2 || TIMEOUT_BITS < 1) begin : g_bad_cfg
        $error("uart_cmd_rx: CLK_FREQ/BAUD must be >= 2 and TIMEOUT_BITS >= 1");
    end

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
    typedef enum logic [1:0] {P_WAIT_HDR, P_WAIT_CMD, P_WAIT_CHK} parse_state_t;

    logic          sync1_q, sync2_q, rx_prev_q;
    bit_state_t    bst_q, bst_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    parse_state_t  pst_q, pst_d;
    logic [7:0]    cmd_q, cmd_d;
    logic          valid_q, valid_d;
    logic [3:0]    move_q, move_d;
    logic [3:0]    speed_q, speed_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;

    logic start_edge, byte_done, stop_err, frame_good, timeout_hit;

    // uart_in is asynchronous; everything downstream sees only sync2_q
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= uart_in;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    assign start_edge = (bst_q == B_IDLE) && rx_prev_q && !sync2_q;

    always_comb begin
        bst_d     = bst_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        stop_err  = 1'b0;
        case (bst_q)
            B_IDLE: begin
                if (start_edge) begin
                    bst_d     = B_START;
                    bit_cnt_d = '0;
                end
            end
            B_START: begin
                if (bit_cnt_q == CW'(HALF_BIT - 1)) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    // A line back high at mid start bit was noise, not a byte
                    bst_d     = sync2_q ? B_IDLE : B_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            B_DATA: begin
                if (bit_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    bit_cnt_d = '0;
                    shift_d   = {sync2_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bst_d = B_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            B_STOP: begin
                if (bit_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    bit_cnt_d = '0;
                    bst_d     = B_IDLE;
                    byte_done = sync2_q;
                    stop_err  = !sync2_q;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: bst_d = B_IDLE;
        endcase
    end

`ifdef FRAME_TIMEOUT_EN
    localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;

    logic [31:0] tmo_cnt_q, tmo_cnt_d;

    // Only idle line time counts; time spent inside a byte never times out
    always_comb begin
        tmo_cnt_d   = tmo_cnt_q;
        timeout_hit = 1'b0;
        if (pst_q == P_WAIT_HDR || start_edge) begin
            tmo_cnt_d = '0;
        end else if (bst_q == B_IDLE) begin
            if (tmo_cnt_q == 32'(TIMEOUT_CLKS - 1)) begin
                timeout_hit = 1'b1;
                tmo_cnt_d   = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tmo_cnt_q <= '0;
        else      tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        pst_d       = pst_q;
        cmd_d       = cmd_q;
        frame_good  = 1'b0;
        frame_err_d = 1'b0;
        if (stop_err) begin
            pst_d       = P_WAIT_HDR;
            frame_err_d = 1'b1;
        end else if (byte_done) begin
            case (pst_q)
                P_WAIT_HDR: if (shift_q == HEADER) pst_d = P_WAIT_CMD;
                P_WAIT_CMD: begin
                    cmd_d = shift_q;
                    pst_d = P_WAIT_CHK;
                end
                P_WAIT_CHK: begin
                    pst_d       = P_WAIT_HDR;
                    frame_good  = (shift_q == (HEADER ^ cmd_q));
                    frame_err_d = (shift_q != (HEADER ^ cmd_q));
                end
                default: pst_d = P_WAIT_HDR;
            endcase
        end else if (timeout_hit) begin
            pst_d       = P_WAIT_HDR;
            frame_err_d = 1'b1;
        end
    end

    // A slot being emptied this cycle may be refilled in the same cycle
    always_comb begin
        valid_d   = valid_q;
        move_d    = move_q;
        speed_d   = speed_q;
        overrun_d = 1'b0;
        if (valid_q && ready) valid_d = 1'b0;
        if (frame_good) begin
            if (!valid_q || ready) begin
                move_d  = cmd_q[3:0];
                speed_d = cmd_q[7:4];
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bst_q       <= B_IDLE;
            bit_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            pst_q       <= P_WAIT_HDR;
            cmd_q       <= '0;
            valid_q     <= 1'b0;
            move_q      <= '0;
            speed_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            bst_q       <= bst_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            pst_q       <= pst_d;
            cmd_q       <= cmd_d;
            valid_q     <= valid_d;
            move_q      <= move_d;
            speed_q     <= speed_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign move_cmd    = move_q;
    assign speed_level = speed_q;
    assign valid       = valid_q;
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx at 10 clocks/bit: directed scenarios plus random frame traffic
// compared against a byte-level frame/holding-register model.
module tb_uart_cmd_rx;

    localparam int CPB = 10;
    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_in;
    logic       ready;
    logic [3:0] move_cmd, speed_level;
    logic       valid, frame_err, overrun;

    int checks = 0;
    int failures = 0;

    uart_cmd_rx #(
        .CLK_FREQ    (50_000_000),
        .BAUD        (5_000_000),
        .HEADER      (8'hA5),
        .TIMEOUT_BITS(20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_in    (uart_in),
        .move_cmd   (move_cmd),
        .speed_level(speed_level),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Observed events, sampled mid-cycle
    int         n_ferr = 0, n_ovr = 0, n_both = 0, n_hs = 0;
    logic [7:0] got_acc[$];

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (frame_err === 1'b1) n_ferr++;
            if (overrun === 1'b1) n_ovr++;
            if (frame_err === 1'b1 && overrun === 1'b1) n_both++;
            if (valid === 1'b1 && ready === 1'b1) begin
                n_hs++;
                got_acc.push_back({speed_level, move_cmd});
            end
        end
    end

    // Reference model: frame position, holding slot, expected event counts
    int         m_pos, m_ferr, m_ovr;
    logic [7:0] m_cmd, m_hold;
    bit         m_hold_vld, m_loaded, m_ready;
    logic [7:0] exp_acc[$];

    task automatic model_reset();
        m_pos = 0; m_ferr = 0; m_ovr = 0; m_cmd = 8'h00; m_hold = 8'h00;
        m_hold_vld = 0; m_loaded = 0; m_ready = 0;
        exp_acc.delete();
    endtask

    task automatic model_good(input logic [7:0] c);
        if (m_hold_vld && !m_ready) begin
            m_ovr++;
        end else begin
            m_hold   = c;
            m_loaded = 1;
            if (m_ready) exp_acc.push_back(c);
            m_hold_vld = !m_ready;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            m_ferr++;
            m_pos = 0;
        end else if (m_pos == 0) begin
            if (b == 8'hA5) m_pos = 1;
        end else if (m_pos == 1) begin
            m_cmd = b;
            m_pos = 2;
        end else begin
            m_pos = 0;
            if (b == (8'hA5 ^ m_cmd)) model_good(m_cmd);
            else m_ferr++;
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input bit r);
        ready   = r;
        m_ready = r;
        if (r && m_hold_vld) begin
            exp_acc.push_back(m_hold);
            m_hold_vld = 0;
        end
    endtask

    task automatic pulse_ready();
        set_ready(1);
        wait_clk(1);
        set_ready(0);
        wait_clk(1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        uart_in = 1'b0;
        wait_clk(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            wait_clk(CPB);
        end
        uart_in = stop_ok;
        wait_clk(CPB);
        uart_in = 1'b1;
        wait_clk(GAP);
        model_byte(b, stop_ok);
    endtask

    task automatic send_frame(input logic [7:0] h, input logic [7:0] c, input logic [7:0] k);
        send_byte(h, 1);
        send_byte(c, 1);
        send_byte(k, 1);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_ready(0);
        for (int i = 0; i < 20; i++) begin
            uart_in = 1'($urandom_range(0, 1));
            wait_clk(1);
        end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid); end
        checks++; if (move_cmd !== 4'h0) begin failures++; $display("FAIL reset_move got=%0h exp=0", move_cmd); end
        checks++; if (speed_level !== 4'h0) begin failures++; $display("FAIL reset_speed got=%0h exp=0", speed_level); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%0b exp=0", frame_err); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
        uart_in = 1'b1;
        wait_clk(2);
        rst = 1'b1;
        model_reset();
        wait_clk(50);
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%0b exp=0", valid); end
        checks++; if (n_ferr !== 0) begin failures++; $display("FAIL idle_frame_err got=%0d exp=0", n_ferr); end
    endtask

    task automatic test_good_frame();
        int hs0;
        set_ready(0);
        send_frame(8'hA5, 8'h21, 8'h84);
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL good_valid got=%0b exp=1", valid); end
        checks++; if (move_cmd !== 4'h1) begin failures++; $display("FAIL good_move got=%0h exp=1", move_cmd); end
        checks++; if (speed_level !== 4'h2) begin failures++; $display("FAIL good_speed got=%0h exp=2", speed_level); end
        hs0 = n_hs;
        pulse_ready();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL good_consume_valid got=%0b exp=0", valid); end
        checks++; if (n_hs !== hs0 + 1) begin failures++; $display("FAIL good_handshakes got=%0d exp=%0d", n_hs, hs0 + 1); end
        checks++; if (move_cmd !== 4'h1) begin failures++; $display("FAIL good_move_hold got=%0h exp=1", move_cmd); end
    endtask

    task automatic test_back_to_back();
        int ovr0;
        set_ready(0);
        ovr0 = n_ovr;
        send_frame(8'hA5, 8'h22, 8'h87);
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL b2b_first_valid got=%0b exp=1", valid); end
        checks++; if (move_cmd !== 4'h2) begin failures++; $display("FAIL b2b_first_move got=%0h exp=2", move_cmd); end
        send_frame(8'hA5, 8'h23, 8'h86);
        checks++; if (n_ovr !== ovr0 + 1) begin failures++; $display("FAIL b2b_overrun got=%0d exp=%0d", n_ovr, ovr0 + 1); end
        checks++; if (move_cmd !== 4'h2) begin failures++; $display("FAIL b2b_move_kept got=%0h exp=2", move_cmd); end
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL b2b_valid_kept got=%0b exp=1", valid); end
        pulse_ready();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", valid); end
    endtask

    task automatic test_bad_checksum();
        int ferr0;
        ferr0 = n_ferr;
        send_frame(8'hA5, 8'h21, 8'h00);
        checks++; if (n_ferr !== ferr0 + 1) begin failures++; $display("FAIL chk_frame_err got=%0d exp=%0d", n_ferr, ferr0 + 1); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL chk_valid got=%0b exp=0", valid); end
        send_frame(8'hA5, 8'h23, 8'h86);
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL chk_next_valid got=%0b exp=1", valid); end
        checks++; if (move_cmd !== 4'h3) begin failures++; $display("FAIL chk_next_move got=%0h exp=3", move_cmd); end
        pulse_ready();
    endtask

    task automatic test_glitch();
        int ferr0, hs0;
        ferr0 = n_ferr;
        hs0 = n_hs;
        uart_in = 1'b0;
        wait_clk(3);
        uart_in = 1'b1;
        wait_clk(150);
        checks++; if (n_ferr !== ferr0) begin failures++; $display("FAIL glitch_frame_err got=%0d exp=%0d", n_ferr, ferr0); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL glitch_valid got=%0b exp=0", valid); end
        send_frame(8'hA5, 8'h24, 8'h81);
        checks++; if (move_cmd !== 4'h4) begin failures++; $display("FAIL glitch_after_move got=%0h exp=4", move_cmd); end
        pulse_ready();
        checks++; if (n_hs !== hs0 + 1) begin failures++; $display("FAIL glitch_handshakes got=%0d exp=%0d", n_hs, hs0 + 1); end
    endtask

    task automatic test_stop_error();
        int ferr0;
        ferr0 = n_ferr;
        send_byte(8'hA5, 1);
        send_byte(8'h21, 0);
        checks++; if (n_ferr !== ferr0 + 1) begin failures++; $display("FAIL stop_frame_err got=%0d exp=%0d", n_ferr, ferr0 + 1); end
        send_byte(8'h84, 1);
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL stop_valid got=%0b exp=0", valid); end
        checks++; if (n_ferr !== ferr0 + 1) begin failures++; $display("FAIL stop_no_extra_err got=%0d exp=%0d", n_ferr, ferr0 + 1); end
    endtask

`ifdef FRAME_TIMEOUT_EN
    task automatic test_timeout();
        int ferr0;
        ferr0 = n_ferr;
        send_byte(8'hA5, 1);
        wait_clk(200);
        m_pos = 0;
        m_ferr++;
        checks++; if (n_ferr !== ferr0 + 1) begin failures++; $display("FAIL timeout_frame_err got=%0d exp=%0d", n_ferr, ferr0 + 1); end
        send_byte(8'h21, 1);
        send_byte(8'h84, 1);
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL timeout_valid got=%0b exp=0", valid); end
    endtask
`endif

    task automatic test_random();
        int         kind, epos;
        logic [7:0] c, k;
        for (int it = 0; it < 40; it++) begin
            set_ready(1'($urandom_range(0, 1)));
            kind = int'($urandom_range(0, 5));
            c = 8'($urandom_range(0, 255));
            k = 8'hA5 ^ c;
            if (kind <= 2) begin
                send_frame(8'hA5, c, k);
            end else if (kind == 3) begin
                send_frame(8'hA5, c, k ^ 8'($urandom_range(1, 255)));
            end else if (kind == 4) begin
                send_byte(c, 1);
            end else begin
                epos = int'($urandom_range(0, 2));
                send_byte(8'hA5, epos != 0);
                send_byte(c, epos != 1);
                send_byte(k, epos != 2);
            end
            checks++; if (valid !== m_hold_vld) begin failures++; $display("FAIL rand_valid it=%0d got=%0b exp=%0b", it, valid, m_hold_vld); end
            if (m_loaded) begin
                checks++;
                if ({speed_level, move_cmd} !== m_hold) begin
                    failures++;
                    $display("FAIL rand_cmd it=%0d got=%02h exp=%02h", it, {speed_level, move_cmd}, m_hold);
                end
            end
        end
        set_ready(1);
        wait_clk(5);
        set_ready(0);
        checks++; if (n_ferr !== m_ferr) begin failures++; $display("FAIL total_frame_err got=%0d exp=%0d", n_ferr, m_ferr); end
        checks++; if (n_ovr !== m_ovr) begin failures++; $display("FAIL total_overrun got=%0d exp=%0d", n_ovr, m_ovr); end
        checks++; if (n_both !== 0) begin failures++; $display("FAIL err_and_overrun_together got=%0d exp=0", n_both); end
        checks++; if (got_acc.size() !== exp_acc.size()) begin failures++; $display("FAIL accepted_count got=%0d exp=%0d", got_acc.size(), exp_acc.size()); end
        for (int i = 0; i < exp_acc.size() && i < got_acc.size(); i++) begin
            checks++;
            if (got_acc[i] !== exp_acc[i]) begin
                failures++;
                $display("FAIL accepted_cmd idx=%0d got=%02h exp=%02h", i, got_acc[i], exp_acc[i]);
            end
        end
    endtask

    initial begin
        #600_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        uart_in = 1'b1;
        ready = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_good_frame();
        test_back_to_back();
        test_bad_checksum();
        test_glitch();
        test_stop_error();
`ifdef FRAME_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
